// File: rtl/atanh_sar_4bit.sv
`default_nettype none
// ============================================================================
// Module   : atanh_sar_4bit
// Purpose  : Inverse 4-bit tanh via 4-step successive approximation over an
//            exact tanh table; valid/ready on both sides, one job in flight.
// Revision : 1.0 - initial release
// ============================================================================
module atanh_sar_4bit #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       In,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       Out1,
   output logic             busy,
   output logic [CNT_W-1:0] conv_cnt
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SEARCH = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [1:0]       r_bit;
   logic [3:0]       r_y;
   logic [3:0]       r_result;
   logic [CNT_W-1:0] r_cnt;
   logic [3:0]       w_trial;

   // T(k) = round(16*tanh(k/4)), saturated at 15; monotone non-decreasing
   function automatic logic [3:0] tanh_lut(input logic [3:0] k);
      case (k)
         4'd0:    tanh_lut = 4'd0;
         4'd1:    tanh_lut = 4'd4;
         4'd2:    tanh_lut = 4'd7;
         4'd3:    tanh_lut = 4'd10;
         4'd4:    tanh_lut = 4'd12;
         4'd5:    tanh_lut = 4'd14;
         4'd6:    tanh_lut = 4'd14;
         default: tanh_lut = 4'd15;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (in_valid)     w_state_nxt = S_SEARCH;
         S_SEARCH: if (r_bit == 2'd0) w_state_nxt = S_DONE;
         S_DONE:   if (out_ready)    w_state_nxt = S_IDLE;
         default:                    w_state_nxt = S_IDLE;
      endcase
   end

   assign w_trial = r_result | (4'b0001 << r_bit);

   // Monotone table makes the greedy MSB-first search land on the largest k
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_y      <= 4'd0;
         r_result <= 4'd0;
         r_bit    <= 2'd3;
         r_cnt    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_y      <= In;
                  r_result <= 4'd0;
                  r_bit    <= 2'd3;
               end
            end
            S_SEARCH: begin
               if (tanh_lut(w_trial) <= r_y) r_result <= w_trial;
               r_bit <= r_bit - 2'd1;
            end
            S_DONE: begin
               if (out_ready) r_cnt <= r_cnt + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   // rst_n gating keeps in_ready low while reset holds the FSM in IDLE
   assign in_ready  = rst_n && (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign busy      = (r_state != S_IDLE);
   assign Out1      = r_result;
   assign conv_cnt  = r_cnt;

endmodule
`default_nettype wire
